// File: rtl/alu_16_if.sv
// Operand/result bundle for alu_16; master drives operands, slave returns registered results.
// No backpressure: in_valid is accepted every cycle, out_valid is a one-cycle strobe.
interface alu_16_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [2:0]       fnsel;
  logic [WIDTH-1:0] z;
  logic             c_n;
  logic             c_n_minus_1;
  logic             out_valid;

  modport master (
    output in_valid, x, y, fnsel,
    input  z, c_n, c_n_minus_1, out_valid
  );

  modport slave (
    input  in_valid, x, y, fnsel,
    output z, c_n, c_n_minus_1, out_valid
  );
endinterface

// File: rtl/alu_16.sv
// Registered ALU (add/sub/and/or/not/pass) with carry out of the top two bits; latency 1 cycle.
// No backpressure: one operation accepted per cycle; results hold until the next valid operation.
module alu_16 #(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst,
  alu_16_if.slave bus
);

  typedef enum logic [2:0] {
    FN_ADD  = 3'b000,
    FN_SUB  = 3'b001,
    FN_AND  = 3'b010,
    FN_OR   = 3'b011,
    FN_RSV4 = 3'b100,
    FN_CMP  = 3'b101,
    FN_PASS = 3'b110,
    FN_RSV7 = 3'b111
  } fn_e;

  fn_e              fn;
  logic [WIDTH-1:0] b_op;
  logic             carry_in;
  logic [WIDTH-1:0] low_sum;
  logic             carry_into_msb;
  logic             carry_out;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] res_z;
  logic             res_cn;
  logic             res_cm;

  logic [WIDTH-1:0] z_q;
  logic             cn_q;
  logic             cm_q;
  logic             vld_q;

  assign fn = fn_e'(bus.fnsel);

  // The adder is split below the MSB so the carry into the top bit is visible directly.
  always_comb begin
    b_op           = bus.y ^ {WIDTH{bus.fnsel[0]}};
    carry_in       = bus.fnsel[0];
    low_sum        = {1'b0, bus.x[WIDTH-2:0]} + {1'b0, b_op[WIDTH-2:0]}
                   + {{(WIDTH-1){1'b0}}, carry_in};
    carry_into_msb = low_sum[WIDTH-1];
    carry_out      = (bus.x[WIDTH-1] & b_op[WIDTH-1])
                   | (carry_into_msb & (bus.x[WIDTH-1] ^ b_op[WIDTH-1]));
    sum            = {bus.x[WIDTH-1] ^ b_op[WIDTH-1] ^ carry_into_msb, low_sum[WIDTH-2:0]};
  end

  always_comb begin
    res_z  = '0;
    res_cn = 1'b0;
    res_cm = 1'b0;
    case (fn)
      FN_ADD, FN_SUB: begin
        res_z  = sum;
        res_cn = carry_out;
        res_cm = carry_into_msb;
      end
      FN_AND:  res_z = bus.x & bus.y;
      FN_OR:   res_z = bus.x | bus.y;
      FN_CMP:  res_z = ~bus.x;
      FN_PASS: res_z = bus.x;
      default: res_z = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q   <= '0;
      cn_q  <= 1'b0;
      cm_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        z_q  <= res_z;
        cn_q <= res_cn;
        cm_q <= res_cm;
      end
    end
  end

  assign bus.z           = z_q;
  assign bus.c_n         = cn_q;
  assign bus.c_n_minus_1 = cm_q;
  assign bus.out_valid   = vld_q;

endmodule

// File: tb/tb_alu_16.sv
// Directed and random checks of alu_16 against an arithmetic reference model.
module tb_alu_16;

  logic clk;
  logic rst;

  alu_16_if #(.WIDTH(16)) ifc ();

  alu_16 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  logic [15:0] exp_z;
  logic        exp_cn;
  logic        exp_cm;
  logic        exp_ov;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: 17-bit sum for carry out; carry into bit 15 recovered as sum[15]^a[15]^b[15].
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] f);
    int unsigned bb;
    int unsigned full;
    logic [15:0] r;
    logic        cn;
    logic        cm;
    r  = 16'h0000;
    cn = 1'b0;
    cm = 1'b0;
    case (f)
      3'd0, 3'd1: begin
        bb   = (f == 3'd1) ? (32'hFFFF - 32'(b)) : 32'(b);
        full = 32'(a) + bb + ((f == 3'd1) ? 32'd1 : 32'd0);
        r    = full[15:0];
        cn   = full[16];
        cm   = full[15] ^ a[15] ^ bb[15];
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = ~a;
      3'd6: r = a;
      default: r = 16'h0000;
    endcase
    return {cn, cm, r};
  endfunction

  task automatic step(input bit r, input bit v, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] f, input string tag);
    logic [17:0] res;
    @(negedge clk);
    rst          = r;
    ifc.in_valid = v;
    ifc.x        = a;
    ifc.y        = b;
    ifc.fnsel    = f;
    #1;
    if (armed) chk({tag, "_no_comb_path"}, ifc.z, exp_z);
    if (r) begin
      exp_z = 16'h0; exp_cn = 1'b0; exp_cm = 1'b0; exp_ov = 1'b0;
    end else begin
      exp_ov = v;
      if (v) begin
        res    = ref_op(a, b, f);
        exp_z  = res[15:0];
        exp_cm = res[16];
        exp_cn = res[17];
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_z"},   ifc.z,                   exp_z);
    chk({tag, "_cn"},  {15'b0, ifc.c_n},         {15'b0, exp_cn});
    chk({tag, "_cm"},  {15'b0, ifc.c_n_minus_1}, {15'b0, exp_cm});
    chk({tag, "_ov"},  {15'b0, ifc.out_valid},   {15'b0, exp_ov});
    armed = 1'b1;
  endtask

  task automatic expect_fixed(input string tag, input logic [15:0] z, input bit cn,
                              input bit cm, input bit ov);
    chk({tag, "_spec_z"},  ifc.z,                   z);
    chk({tag, "_spec_cn"}, {15'b0, ifc.c_n},         {15'b0, cn});
    chk({tag, "_spec_cm"}, {15'b0, ifc.c_n_minus_1}, {15'b0, cm});
    chk({tag, "_spec_ov"}, {15'b0, ifc.out_valid},   {15'b0, ov});
  endtask

  initial begin
    rst          = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.x        = '0;
    ifc.y        = '0;
    ifc.fnsel    = '0;
    exp_z = 16'h0; exp_cn = 1'b0; exp_cm = 1'b0; exp_ov = 1'b0;

    step(1'b1, 1'b0, 16'h0, 16'h0, 3'd0, "reset0");
    step(1'b1, 1'b1, 16'h1234, 16'h4321, 3'd0, "reset1");
    expect_fixed("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back directed vectors with known results.
    step(1'b0, 1'b1, 16'd5, 16'd12, 3'd0, "add_5_12");
    expect_fixed("add_5_12", 16'h0011, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd5, 16'd12, 3'd1, "sub_5_12");
    expect_fixed("sub_5_12", 16'hFFF9, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd5, 16'd12, 3'd2, "and_5_12");
    expect_fixed("and_5_12", 16'h0004, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd5, 16'd12, 3'd3, "or_5_12");
    expect_fixed("or_5_12", 16'h000D, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd5, 16'd12, 3'd5, "cmp_5");
    expect_fixed("cmp_5", 16'hFFFA, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd5, 16'd12, 3'd6, "pass_5");
    expect_fixed("pass_5", 16'h0005, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h7FFF, 16'h0001, 3'd0, "add_ovf");
    expect_fixed("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'hFFFF, 16'h0001, 3'd0, "add_wrap");
    expect_fixed("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'd12, 16'd5, 3'd1, "sub_12_5");
    expect_fixed("sub_12_5", 16'h0007, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h8000, 16'h0001, 3'd1, "sub_ovf");
    expect_fixed("sub_ovf", 16'h7FFF, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'hAAAA, 16'h5555, 3'd4, "rsv4");
    expect_fixed("rsv4", 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'hAAAA, 16'h5555, 3'd7, "rsv7");
    expect_fixed("rsv7", 16'h0000, 1'b0, 1'b0, 1'b1);

    // A result followed by idle cycles must hold.
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 3'd0, "hold_src");
    expect_fixed("hold_src", 16'hFFFE, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h1111, 16'h2222, 3'd3, $sformatf("hold%0d", i));
      expect_fixed($sformatf("hold%0d", i), 16'hFFFE, 1'b1, 1'b1, 1'b0);
    end

    // Reset mid-stream discards the coincident operation; next valid resumes with latency 1.
    step(1'b1, 1'b1, 16'h00F0, 16'h0F00, 3'd3, "mid_rst");
    expect_fixed("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h00F0, 16'h0F00, 3'd3, "post_rst");
    expect_fixed("post_rst", 16'h0FF0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
           $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_16.md
ALU_16 -- requirements
Module: alu_16

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; all requirements below stated for WIDTH=16.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operands and fnsel sampled at this clk edge when high.
REQ-006 x  input  16  operand A.
REQ-007 y  input  16  operand B.
REQ-008 fnsel  input  3  function select.
REQ-009 z  output  16  registered result.
REQ-010 c_n  output  1  registered carry out of bit 15.
REQ-011 c_n_minus_1  output  1  registered carry out of bit 14, i.e. carry into bit 15.
REQ-012 out_valid  output  1  high for one cycle when z/c_n/c_n_minus_1 hold a new result.

Function
REQ-013 fnsel decode:
- 000 ADD: z = x + y.
- 001 SUB: z = x + ~y + 1.
- 010 AND: z = x & y.
- 011 OR: z = x | y.
- 100 reserved: z = 0.
- 101 CMP: z = ~x, bitwise one's complement; y ignored.
- 110 PASS: z = x.
- 111 reserved: z = 0.
REQ-014 ADD/SUB share one 16-bit ripple or equivalent adder: second operand = y XOR {16{fnsel[0]}}, carry-in = fnsel[0].
REQ-015 Arithmetic is modulo 2^16; the 17th bit goes only to c_n.
REQ-016 c_n = adder carry out of bit 15; c_n_minus_1 = adder carry out of bit 14.
- Signed overflow = c_n XOR c_n_minus_1; this block does not compute it.
- For SUB, c_n=1 means no borrow (x >= y unsigned).
REQ-017 For fnsel not 000/001, c_n and c_n_minus_1 SHALL be 0.
REQ-018 Latency is exactly one cycle. On a clk edge with in_valid=1 and rst=0:
- z, c_n and c_n_minus_1 load the result of x, y, fnsel sampled at that edge.
- out_valid is 1 for the following cycle.
REQ-019 On a clk edge with in_valid=0 and rst=0:
- z, c_n and c_n_minus_1 hold their previous values.
- out_valid goes to 0.
REQ-020 Back-to-back in_valid=1 SHALL produce one result per cycle; no stall and no backpressure.
REQ-021 No X/Z may propagate to outputs from reserved fnsel codes.
REQ-022 Outputs SHALL depend only on registered state; no combinational path from inputs to outputs.

Reset
REQ-023 When rst=1 at a clk edge: z=0x0000, c_n=0, c_n_minus_1=0, out_valid=0.
REQ-024 rst has priority over in_valid; an operation presented in the same cycle as rst is discarded.
REQ-025 Reset asserted mid-stream clears any pending result; the first valid after rst deasserts produces a result one cycle later.

Verification
REQ-026 x=5, y=12, fnsel=000 -> z=0x0011, c_n=0, c_n_minus_1=0, out_valid=1 next cycle.
REQ-027 x=5, y=12, sequentially fnsel=001, 010, 011, 101, 110 -> z=0xFFF9, 0x0004, 0x000D, 0xFFFA, 0x0005; c_n=c_n_minus_1=0 for all.
REQ-028 ADD x=0x7FFF, y=0x0001 -> z=0x8000, c_n=0, c_n_minus_1=1.
- ADD x=0xFFFF, y=0x0001 -> z=0x0000, c_n=1, c_n_minus_1=1.
REQ-029 SUB x=12, y=5 -> z=0x0007, c_n=1, c_n_minus_1=1.
- SUB x=0x8000, y=0x0001 -> z=0x7FFF, c_n=1, c_n_minus_1=0.
REQ-030 fnsel=100 and fnsel=111 with x=0xAAAA, y=0x5555 -> z=0x0000, c_n=0, c_n_minus_1=0.
REQ-031 Reset and hold:
- rst=1 together with in_valid=1 -> next cycle z=0, out_valid=0.
- Then in_valid=0 for 3 cycles after a result -> z holds, out_valid=0.
